// File: rtl/bcd_sevenseg_scan.sv
// Two-digit multiplexed 7-segment driver with a double-buffered BCD word.
// Optional LEAD_ZERO_BLANK_EN darkens the tens digit when it is zero.
module bcd_sevenseg_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_in,
  input  logic       bcd_valid,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       frame_tick
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          idx_q, idx_d;
  logic [7:0]    pend_q, pend_d;
  logic [7:0]    disp_q, disp_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          tick_q, tick_d;
  logic          last;
  logic          boundary;
  logic [3:0]    nib;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    last     = (div_q == DIV_LAST);
    boundary = last && idx_q;
    div_d    = last ? '0 : div_q + 1'b1;
    idx_d    = last ? ~idx_q : idx_q;
    pend_d   = bcd_valid ? bcd_in : pend_q;
    disp_d   = disp_q;
    // A strobe landing on the boundary goes straight to the display
    if (boundary) disp_d = bcd_valid ? bcd_in : pend_q;
    tick_d   = boundary;
    nib      = idx_q ? disp_q[7:4] : disp_q[3:0];
    seg_d    = decode(nib);
    an_d     = idx_q ? 2'b01 : 2'b10;
`ifdef LEAD_ZERO_BLANK_EN
    if (idx_q && (disp_q[7:4] == 4'd0)) begin
      seg_d = 7'h7F;
      an_d  = 2'b11;
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= 1'b0;
      pend_q <= 8'h00;
      disp_q <= 8'h00;
      seg_q  <= 7'h7F;
      an_q   <= 2'b11;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Scoreboard bench for bcd_sevenseg_scan (SCAN_DIV=4, 8-cycle frames).
// Each frame's expected digits are queued; a monitor checks them per frame.
module tb_bcd_sevenseg_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bcd_in;
  logic       bcd_valid;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] seg_u;
    logic [6:0] seg_t;
    logic [1:0] an_t;
  } exp_t;

  exp_t exq[$];

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] T0_SEG = 7'h7F;
  localparam logic [1:0] T0_AN  = 2'b11;
`else
  localparam logic [6:0] T0_SEG = 7'h40;
  localparam logic [1:0] T0_AN  = 2'b01;
`endif

  localparam exp_t E00 = '{7'h40, T0_SEG, T0_AN};
  localparam exp_t E15 = '{7'h12, 7'h79, 2'b01};
  localparam exp_t E12 = '{7'h24, 7'h79, 2'b01};
  localparam exp_t E1A = '{7'h3F, 7'h79, 2'b01};
  localparam exp_t E98 = '{7'h00, 7'h10, 2'b01};
  localparam exp_t E07 = '{7'h78, T0_SEG, T0_AN};

  bcd_sevenseg_scan #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [6:0] s, input logic [1:0] a,
                     input logic [6:0] es, input logic [1:0] ea);
    checks++;
    if (s !== es || a !== ea) begin
      errors++;
      $display("FAIL %s: seg_n=%h an_n=%b, expected seg_n=%h an_n=%b",
               nm, s, a, es, ea);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 20);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no frame_tick in %0d cycles", n);
    end
  endtask

  task automatic strobe(input logic [7:0] w);
    bcd_in    = w;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  task automatic mid_test(input exp_t old_e, input logic [7:0] w1,
                          input logic [7:0] w2, input bit two,
                          input exp_t new_e);
    exq.push_back(old_e);
    wait_tick();
    repeat (2) @(negedge clk);
    strobe(w1);
    if (two) strobe(w2);
    exq.push_back(new_e);
    wait_tick();
  endtask

  task automatic first_frame(input string nm);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 4) chk({nm, "_units"}, seg_n, an_n, 7'h40, 2'b10);
      else chk({nm, "_tens"}, seg_n, an_n, T0_SEG, T0_AN);
    end
  endtask

  // Monitor: frame period and per-frame digit contents
  initial begin : monitor
    exp_t e;
    int   cnt  = 0;
    int   cyc  = 0;
    bit   seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt  = 0;
        seen = 0;
        cyc  = 0;
      end else begin
        cyc++;
        if (cnt > 0) begin
          if (9 - cnt <= 4) chk("frame_units", seg_n, an_n, e.seg_u, 2'b10);
          else chk("frame_tens", seg_n, an_n, e.seg_t, e.an_t);
          cnt--;
        end
        if (frame_tick) begin
          if (seen) begin
            checks++;
            if (cyc != 8) begin
              errors++;
              $display("FAIL tick_period: got %0d cycles, expected 8", cyc);
            end
          end
          seen = 1;
          cyc  = 0;
          if (exq.size() > 0) begin
            e   = exq.pop_front();
            cnt = 8;
          end
        end
      end
    end
  end

  initial begin : stim
    rst       = 1'b1;
    bcd_in    = 8'h00;
    bcd_valid = 1'b0;
    #1;
    chk("reset_async", seg_n, an_n, 7'h7F, 2'b11);
    repeat (3) @(negedge clk);
    chk("reset_hold", seg_n, an_n, 7'h7F, 2'b11);
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick: frame_tick=%b expected 0", frame_tick);
    end
    rst = 1'b0;
    first_frame("init");

    mid_test(E00, 8'h15, 8'h00, 0, E15);
    mid_test(E15, 8'h07, 8'h12, 1, E12);
    mid_test(E12, 8'h1A, 8'h00, 0, E1A);

    exq.push_back(E1A);
    wait_tick();
    repeat (7) @(negedge clk);
    bcd_in    = 8'h98;
    bcd_valid = 1'b1;
    exq.push_back(E98);
    @(negedge clk);
    bcd_valid = 1'b0;

    mid_test(E98, 8'h07, 8'h00, 0, E07);

    wait_tick();
    repeat (3) @(negedge clk);
    #2;
    rst       = 1'b1;
    bcd_in    = 8'h55;
    bcd_valid = 1'b1;
    #1;
    chk("reset_mid", seg_n, an_n, 7'h7F, 2'b11);
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_tick: frame_tick=%b expected 0", frame_tick);
    end
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    bcd_valid = 1'b0;
    first_frame("post_rst");

    mid_test(E00, 8'h15, 8'h00, 0, E15);
    repeat (10) @(negedge clk);

    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d left, expected 0", exq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
